spi_master_gen: RTL and testbench
=================================

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per word.
REQ-002 SHALL have parameter CLK_DIV, default 750, CLK cycles per SCLK half-period (>=2).
REQ-003 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-005 SHALL have parameter LSB_FIRST, default 0: 0 = MSB first on MOSI and MISO.
REQ-006 SHALL have parameter LEN_W, default 4, width of word-count input.
REQ-007 SHALL have port CLK, input, 1 bit: system clock; all logic on posedge CLK; SCLK is derived, never a clock.
REQ-008 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port START, input, 1 bit: one-cycle transaction request.
REQ-010 SHALL have port LEN, input, LEN_W bits: words in transaction minus 1, sampled with START.
REQ-011 SHALL have port DIN, input, DATA_W bits: word to transmit.
REQ-012 SHALL have port MISO, input, 1 bit: serial data from slave.
REQ-013 SHALL have port MOSI, output, 1 bit: serial data to slave.
REQ-014 SHALL have port SCLK, output, 1 bit: serial clock.
REQ-015 SHALL have port CS_N, output, 1 bit: active-low slave select.
REQ-016 SHALL have port BUSY, output, 1 bit: transaction in progress.
REQ-017 SHALL have port DOUT, output, DATA_W bits: last received word.
REQ-018 SHALL have port DOUT_VALID, output, 1 bit: one-cycle pulse, DOUT updated.
REQ-019 SHALL have port DONE, output, 1 bit: one-cycle pulse at end of transaction.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, XFER, HOLD, GAP; all registers reset to IDLE values.
REQ-021 In IDLE, START=1 SHALL capture DIN and LEN; next cycle: state SETUP, CS_N=0, BUSY=1.
REQ-022 START while BUSY=1 SHALL be ignored, with no effect on the transfer in progress.
REQ-023 A divider counter SHALL produce a tick every CLK_DIV cycles, restarted at CS_N fall; SCLK edge k (k=1..2*DATA_W*(LEN+1)) SHALL occur on tick k+0 after SETUP, i.e. CLK_DIV*k cycles after CS_N fall.
REQ-024 SCLK SHALL equal CPOL outside XFER and toggle only on ticks in XFER; no glitches (registered output).
REQ-025 CPHA=0: first bit on MOSI SHALL be driven when CS_N falls; MISO sampled on odd edges; MOSI shifted on even edges.
REQ-026 CPHA=1: MOSI SHALL be shifted on odd edges and MISO sampled on even edges; MOSI=first bit from CS_N fall.
REQ-027 After the final sample of each word, DOUT SHALL update and DOUT_VALID SHALL pulse the following cycle.
REQ-028 For non-final words, DIN SHALL be captured on the cycle DOUT_VALID=1 and transmitted as the next word with no SCLK gap.
REQ-029 After the last edge, HOLD SHALL keep CS_N=0 for CLK_DIV cycles, then CS_N=1 and state GAP.
REQ-030 GAP SHALL last CLK_DIV cycles with BUSY=1; then IDLE, BUSY=0, DONE pulses for one cycle.
REQ-031 CS_N low time SHALL be CLK_DIV*(2*DATA_W*(LEN+1)+1) cycles; LEN=all-ones SHALL give 2^LEN_W words.
REQ-032 Bit order SHALL follow LSB_FIRST identically for MOSI and DOUT assembly.
REQ-033 MOSI SHALL be 0 while CS_N=1.

Reset
REQ-034 RESET_N=0 SHALL immediately force: IDLE, SCLK=CPOL, CS_N=1, MOSI=0, BUSY=0, DOUT=0, DOUT_VALID=0, DONE=0, counters 0.
REQ-035 Reset mid-transfer SHALL abort with no DOUT_VALID or DONE; first START after RESET_N rises SHALL be accepted normally.

Verification
REQ-036 Defaults except CLK_DIV=2, LEN=0, DIN=8'hA5, slave returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1, DOUT=8'h3C with one DOUT_VALID, CS_N low 34 cycles, DONE once.
REQ-037 All four CPOL/CPHA combos, DIN=8'h81, loopback MISO=MOSI -> DOUT=8'h81, SCLK idle=CPOL, 8 sample edges of correct polarity.
REQ-038 LEN=2, DIN supplied 8'h11/8'h22/8'h33 at START/DOUT_VALID -> 48 contiguous SCLK edges, 3 DOUT_VALID pulses, loopback DOUT sequence 11,22,33.
REQ-039 START pulsed during BUSY and RESET_N asserted at edge 7 -> second START ignored; at reset CS_N=1, SCLK=CPOL same cycle, no DONE; new START completes normally.
REQ-040 DATA_W=12, LSB_FIRST=1, DIN=12'h801 -> MOSI first bit 1, last bit 1, loopback DOUT=12'h801.

Source files
------------

// File: rtl/spi_master_gen.sv
// SPI master with parameterised word width, clock divider, CPOL/CPHA and bit order.
// Streams LEN+1 back-to-back words under one CS_N assertion; all timing derives from CLK.
module spi_master_gen #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 750,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0,
    parameter int LEN_W     = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [DATA_W-1:0] DIN,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic              CS_N,
    output logic              BUSY,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    output logic              DONE
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [EW-1:0]     edge_cnt;
    logic [LEN_W-1:0]  rem;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] nxt;
    logic              first_word;
    logic              more;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    logic              tick;
    logic              last_edge;
    logic              odd_edge;
    logic              sample_ev;
    logic              final_sample;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_next;

    // edge_cnt holds the number of edges already issued in this word, so edge_cnt+1 is the next one
    assign tick         = (cnt == CNT_W'(CLK_DIV - 1));
    assign last_edge    = (edge_cnt == EW'(EDGES - 1));
    assign odd_edge     = ~edge_cnt[0];
    assign sample_ev    = CPHA ? ~odd_edge : odd_edge;
    assign final_sample = sample_ev && (CPHA ? last_edge : (edge_cnt == EW'(EDGES - 2)));
    assign rx_next      = LSB_FIRST ? {MISO, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], MISO};
    assign tx_next      = shift_word(tx);

    // NOTE: every state register uses <= so all updates see pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cnt        <= '0;
            edge_cnt   <= '0;
            rem        <= '0;
            tx         <= '0;
            rx         <= '0;
            nxt        <= '0;
            first_word <= 1'b0;
            more       <= 1'b0;
            MOSI       <= 1'b0;
            SCLK       <= CPOL;
            CS_N       <= 1'b1;
            BUSY       <= 1'b0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DOUT_VALID <= 1'b0;
            DONE       <= 1'b0;
            if (DOUT_VALID && more)
                nxt <= DIN;
            if (state != IDLE)
                cnt <= tick ? '0 : cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (START) begin
                        tx         <= DIN;
                        MOSI       <= first_bit(DIN);
                        rem        <= LEN;
                        cnt        <= '0;
                        edge_cnt   <= '0;
                        first_word <= 1'b1;
                        CS_N       <= 1'b0;
                        BUSY       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: state <= XFER;
                XFER: begin
                    if (tick) begin
                        SCLK     <= ~SCLK;
                        edge_cnt <= last_edge ? '0 : edge_cnt + EW'(1);
                        if (sample_ev)
                            rx <= rx_next;
                        if (final_sample) begin
                            DOUT       <= rx_next;
                            DOUT_VALID <= 1'b1;
                            more       <= (rem != '0);
                        end
                        // The next word is loaded on the edge where its first bit is due
                        if (!CPHA) begin
                            if (!odd_edge && !last_edge) begin
                                tx   <= tx_next;
                                MOSI <= first_bit(tx_next);
                            end else if (last_edge && rem != '0) begin
                                tx   <= nxt;
                                MOSI <= first_bit(nxt);
                            end
                        end else begin
                            if (odd_edge && edge_cnt != '0) begin
                                tx   <= tx_next;
                                MOSI <= first_bit(tx_next);
                            end else if (edge_cnt == '0 && !first_word) begin
                                tx   <= nxt;
                                MOSI <= first_bit(nxt);
                            end
                        end
                        if (last_edge) begin
                            first_word <= 1'b0;
                            if (rem == '0)
                                state <= HOLD;
                            else
                                rem <= rem - LEN_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        CS_N  <= 1'b1;
                        MOSI  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: four 8-bit CPOL/CPHA variants plus a 12-bit LSB-first variant,
// all with CLK_DIV=2, observed by a negedge monitor that counts edges, pulses and captured MOSI bits.
module tb_spi_master_gen;

    logic        clk;
    logic        rst_n;
    logic        mon_clr;
    bit          lb0;
    logic [4:0]  start, miso_v, mosi_v, sclk_v, cs_v, busy_v, dv_v, done_v;
    logic [11:0] din_v  [5];
    logic [11:0] dout_v [5];
    logic [3:0]  len_v  [5];

    int n_checks;
    int n_err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master_gen #(
            .DATA_W(8), .CLK_DIV(2), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)),
            .LSB_FIRST(1'b0), .LEN_W(4)
        ) u_dut (
            .CLK(clk), .RESET_N(rst_n), .START(start[g]), .LEN(len_v[g]),
            .DIN(din_v[g][7:0]), .MISO(miso_v[g]), .MOSI(mosi_v[g]), .SCLK(sclk_v[g]),
            .CS_N(cs_v[g]), .BUSY(busy_v[g]), .DOUT(dout_v[g][7:0]),
            .DOUT_VALID(dv_v[g]), .DONE(done_v[g])
        );
        assign dout_v[g][11:8] = 4'h0;
    end

    spi_master_gen #(
        .DATA_W(12), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1), .LEN_W(4)
    ) u_dut12 (
        .CLK(clk), .RESET_N(rst_n), .START(start[4]), .LEN(len_v[4]),
        .DIN(din_v[4]), .MISO(miso_v[4]), .MOSI(mosi_v[4]), .SCLK(sclk_v[4]),
        .CS_N(cs_v[4]), .BUSY(busy_v[4]), .DOUT(dout_v[4]),
        .DOUT_VALID(dv_v[4]), .DONE(done_v[4])
    );

    // Slave model for instance 0: shifts out 8'h3C MSB first, advancing on falling (shift) edges
    logic [7:0] sl_sr;
    assign miso_v[0]   = lb0 ? mosi_v[0] : sl_sr[7];
    assign miso_v[4:1] = mosi_v[4:1];

    // Sampling edge is rising when CPOL == CPHA
    localparam logic [4:0] SAMP_RISE = 5'b11001;

    logic [4:0]  sclk_prev, cs_prev, first_mosi;
    int          edges[5], cs_cyc[5], dv_cnt[5], done_cnt[5], samp_cnt[5], since[5], max_gap[5];
    logic [11:0] cap[5];
    logic [11:0] dv_log[5][4];

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            sclk_prev[i] <= sclk_v[i];
            cs_prev[i]   <= cs_v[i];
            if (mon_clr) begin
                edges[i] <= 0; cs_cyc[i] <= 0; dv_cnt[i] <= 0; done_cnt[i] <= 0;
                samp_cnt[i] <= 0; since[i] <= 0; max_gap[i] <= 0; cap[i] <= '0;
                first_mosi[i] <= 1'b0;
            end else begin
                if (!cs_v[i]) cs_cyc[i] <= cs_cyc[i] + 1;
                if (dv_v[i]) begin
                    dv_cnt[i] <= dv_cnt[i] + 1;
                    if (dv_cnt[i] < 4) dv_log[i][dv_cnt[i]] <= dout_v[i];
                end
                if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (!cs_v[i] && sclk_v[i] != sclk_prev[i]) begin
                    edges[i] <= edges[i] + 1;
                    since[i] <= 0;
                    if (edges[i] != 0 && since[i] + 1 > max_gap[i]) max_gap[i] <= since[i] + 1;
                    if (sclk_v[i] == SAMP_RISE[i]) begin
                        cap[i]      <= {cap[i][10:0], mosi_v[i]};
                        samp_cnt[i] <= samp_cnt[i] + 1;
                        if (samp_cnt[i] == 0) first_mosi[i] <= mosi_v[i];
                    end
                end else begin
                    since[i] <= since[i] + 1;
                end
            end
        end
        if (mon_clr)
            sl_sr <= 8'h00;
        else if (cs_prev[0] && !cs_v[0])
            sl_sr <= 8'h3C;
        else if (!cs_v[0] && sclk_v[0] != sclk_prev[0] && !sclk_v[0])
            sl_sr <= {sl_sr[6:0], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on instance i; d1/d2 are supplied on the 1st/2nd DOUT_VALID,
    // and a stray START with different LEN/DIN is pulsed stray_at cycles after the real one.
    task automatic xfer(input int i, input logic [11:0] d0, input logic [11:0] d1,
                        input logic [11:0] d2, input logic [3:0] l, input int stray_at);
        int fed;
        bit ok;
        fed = 0;
        ok  = 1'b0;
        @(posedge clk); #1; mon_clr = 1'b1;
        @(posedge clk); #1; mon_clr = 1'b0; din_v[i] = d0; len_v[i] = l; start[i] = 1'b1;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(posedge clk); #1;
            start[i] = (c == stray_at);
            if (c == stray_at) begin
                din_v[i] = 12'h05A;
                len_v[i] = 4'd1;
            end
            if (dv_v[i]) begin
                fed++;
                din_v[i] = (fed == 1) ? d1 : d2;
            end
            if (done_v[i]) ok = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("x%0d_done_seen", i), 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; mon_clr = 1'b1; lb0 = 1'b1; start = '0;
        n_checks = 0; n_err = 0;
        for (int i = 0; i < 5; i++) begin
            din_v[i] = '0;
            len_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset values, including CPOL=1 idle level on instances 2 and 3
        check("rst_cs_n", 32'(cs_v), 32'h1F);
        check("rst_sclk", 32'(sclk_v), 32'h0C);
        check("rst_mosi", 32'(mosi_v), 32'h00);
        check("rst_busy", 32'(busy_v), 32'h00);
        check("rst_dv",   32'(dv_v), 32'h00);
        check("rst_done", 32'(done_v), 32'h00);
        check("rst_dout0", 32'(dout_v[0]), 32'h0);
        check("rst_dout4", 32'(dout_v[4]), 32'h0);
        rst_n = 1'b1;

        // Basic word against a slave returning 8'h3C
        lb0 = 1'b0;
        xfer(0, 12'h0A5, 12'h0, 12'h0, 4'd0, -1);
        check("basic_mosi_bits", 32'(cap[0][7:0]), 32'hA5);
        check("basic_dout", 32'(dout_v[0]), 32'h3C);
        check("basic_dv_cnt", 32'(dv_cnt[0]), 32'd1);
        check("basic_dv_word", 32'(dv_log[0][0]), 32'h3C);
        check("basic_cs_low", 32'(cs_cyc[0]), 32'd34);
        check("basic_done_cnt", 32'(done_cnt[0]), 32'd1);
        check("basic_idle_busy_mosi", 32'({busy_v[0], mosi_v[0], cs_v[0]}), 32'b001);
        lb0 = 1'b1;

        // All four CPOL/CPHA combinations in loopback
        for (int i = 0; i < 4; i++) begin
            xfer(i, 12'h081, 12'h0, 12'h0, 4'd0, -1);
            check($sformatf("mode%0d_dout", i), 32'(dout_v[i]), 32'h81);
            check($sformatf("mode%0d_mosi_bits", i), 32'(cap[i][7:0]), 32'h81);
            check($sformatf("mode%0d_samples", i), 32'(samp_cnt[i]), 32'd8);
            check($sformatf("mode%0d_edges", i), 32'(edges[i]), 32'd16);
            check($sformatf("mode%0d_sclk_idle", i), 32'(sclk_v[i]), 32'(i / 2));
            check($sformatf("mode%0d_done", i), 32'(done_cnt[i]), 32'd1);
        end

        // Three back-to-back words with DIN supplied on each DOUT_VALID
        xfer(0, 12'h011, 12'h022, 12'h033, 4'd2, -1);
        check("multi_dv_cnt", 32'(dv_cnt[0]), 32'd3);
        check("multi_word0", 32'(dv_log[0][0]), 32'h11);
        check("multi_word1", 32'(dv_log[0][1]), 32'h22);
        check("multi_word2", 32'(dv_log[0][2]), 32'h33);
        check("multi_edges", 32'(edges[0]), 32'd48);
        check("multi_max_gap", 32'(max_gap[0]), 32'd2);
        check("multi_cs_low", 32'(cs_cyc[0]), 32'd98);
        check("multi_done", 32'(done_cnt[0]), 32'd1);

        // START while busy must be ignored
        xfer(0, 12'h0A5, 12'h0, 12'h0, 4'd0, 5);
        check("stray_dout", 32'(dout_v[0]), 32'hA5);
        check("stray_edges", 32'(edges[0]), 32'd16);
        check("stray_cs_low", 32'(cs_cyc[0]), 32'd34);
        check("stray_dv_cnt", 32'(dv_cnt[0]), 32'd1);
        check("stray_done", 32'(done_cnt[0]), 32'd1);

        // Reset right after SCLK edge 7 (CS_N falls at posedge F, edge 7 lands at F+14)
        @(posedge clk); #1; mon_clr = 1'b1;
        @(posedge clk); #1; mon_clr = 1'b0; din_v[0] = 12'h0A5; len_v[0] = 4'd0; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("rstmid_sclk_after_edge7", 32'(sclk_v[0]), 32'd1);
        check("rstmid_edges_seen", 32'(edges[0]), 32'd6);
        rst_n = 1'b0;
        #1;
        check("rstmid_cs_n", 32'(cs_v[0]), 32'd1);
        check("rstmid_sclk", 32'(sclk_v[0]), 32'd0);
        check("rstmid_busy_mosi", 32'({busy_v[0], mosi_v[0]}), 32'd0);
        check("rstmid_dout", 32'(dout_v[0]), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rstmid_no_dv", 32'(dv_cnt[0]), 32'd0);
        check("rstmid_no_done", 32'(done_cnt[0]), 32'd0);
        check("rstmid_stays_idle", 32'({cs_v[0], busy_v[0]}), 32'b10);

        xfer(0, 12'h05A, 12'h0, 12'h0, 4'd0, -1);
        check("postrst_dout", 32'(dout_v[0]), 32'h5A);
        check("postrst_dv_cnt", 32'(dv_cnt[0]), 32'd1);
        check("postrst_done", 32'(done_cnt[0]), 32'd1);

        // 12-bit LSB-first instance; MOSI bits are captured first-bit-in-MSB
        xfer(4, 12'h801, 12'h0, 12'h0, 4'd0, -1);
        check("w12_first_bit", 32'(first_mosi[4]), 32'd1);
        check("w12_last_bit", 32'(cap[4][0]), 32'd1);
        check("w12_mosi_bits", 32'(cap[4]), 32'h801);
        check("w12_dout", 32'(dout_v[4]), 32'h801);
        check("w12_cs_low", 32'(cs_cyc[4]), 32'd50);

        xfer(4, 12'h00F, 12'h0, 12'h0, 4'd0, -1);
        check("w12_order_bits", 32'(cap[4]), 32'hF00);
        check("w12_order_dout", 32'(dout_v[4]), 32'h00F);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
